// File: rtl/draw_pkg.sv
// Shared types and helpers for the draw_* rasteriser family.
// Holds the FSM state encoding, the fill/outline mode constants and the signed min/max helpers.
package draw_pkg;

    localparam int DRAW_CORDW = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ROW   = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } draw_state_e;

    localparam logic DRAW_MODE_FILL    = 1'b0;
    localparam logic DRAW_MODE_OUTLINE = 1'b1;

    function automatic logic signed [DRAW_CORDW-1:0] smin(
        input logic signed [DRAW_CORDW-1:0] a,
        input logic signed [DRAW_CORDW-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [DRAW_CORDW-1:0] smax(
        input logic signed [DRAW_CORDW-1:0] a,
        input logic signed [DRAW_CORDW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/draw_span_1d.sv
// One-dimensional pixel stepper: walks a contiguous span x_start..x_end, or just the two
// discrete points x_start and x_end. Advances only while oe_i is high.
module draw_span_1d
    import draw_pkg::*;
#(
    parameter int CORDW = DRAW_CORDW
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    oe_i,
    input  logic signed [CORDW-1:0] x_start_i,
    input  logic signed [CORDW-1:0] x_end_i,
    input  logic                    two_point_i,
    output logic signed [CORDW-1:0] x_o,
    output logic                    drawing_o,
    output logic                    done_o
);

    localparam logic signed [CORDW-1:0] ONE = {{(CORDW-1){1'b0}}, 1'b1};

    logic                    active_q, active_d;
    logic                    two_q, two_d;
    logic signed [CORDW-1:0] x_q, x_d;
    logic signed [CORDW-1:0] end_q, end_d;
    logic                    last_s;

    // Equality test before any increment keeps x from ever stepping past end.
    assign last_s    = (x_q == end_q);
    assign x_o       = x_q;
    assign drawing_o = active_q & oe_i;
    assign done_o    = active_q & oe_i & last_s;

    // Next-state for the stepper position and run flag.
    always_comb begin
        active_d = active_q;
        two_d    = two_q;
        x_d      = x_q;
        end_d    = end_q;
        if (start_i) begin
            active_d = 1'b1;
            two_d    = two_point_i;
            x_d      = x_start_i;
            end_d    = x_end_i;
        end else if (active_q && oe_i) begin
            if (last_s) begin
                active_d = 1'b0;
            end else if (two_q) begin
                x_d = end_q;
            end else begin
                x_d = x_q + ONE;
            end
        end else begin
            active_d = active_q;
        end
    end

    // Stepper state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            active_q <= 1'b0;
            two_q    <= 1'b0;
            x_q      <= '0;
            end_q    <= '0;
        end else begin
            active_q <= active_d;
            two_q    <= two_d;
            x_q      <= x_d;
            end_q    <= end_d;
        end
    end

endmodule

// File: rtl/draw_rectangle_mode.sv
// Filled / outline rectangle rasteriser with optional inclusive clip window.
// Rows run top-to-bottom, pixels left-to-right; one pixel per enabled cycle.
module draw_rectangle_mode
    import draw_pkg::*;
#(
    parameter int CORDW = DRAW_CORDW
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    oe_i,
    input  logic                    mode_i,
    input  logic                    clip_en_i,
    input  logic signed [CORDW-1:0] clip_x0_i,
    input  logic signed [CORDW-1:0] clip_y0_i,
    input  logic signed [CORDW-1:0] clip_x1_i,
    input  logic signed [CORDW-1:0] clip_y1_i,
    input  logic signed [CORDW-1:0] x0_i,
    input  logic signed [CORDW-1:0] y0_i,
    input  logic signed [CORDW-1:0] x1_i,
    input  logic signed [CORDW-1:0] y1_i,
    output logic signed [CORDW-1:0] x_o,
    output logic signed [CORDW-1:0] y_o,
    output logic                    drawing_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam logic signed [CORDW-1:0] ONE   = {{(CORDW-1){1'b0}}, 1'b1};
    localparam logic signed [CORDW-1:0] C_MIN = {1'b1, {(CORDW-1){1'b0}}};
    localparam logic signed [CORDW-1:0] C_MAX = {1'b0, {(CORDW-1){1'b1}}};

    draw_state_e state_q, state_d;
    logic        mode_q, mode_d;
    logic        clip_en_q, clip_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Raw request, captured at start.
    logic signed [CORDW-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic signed [CORDW-1:0] clx0_q, clx0_d, cly0_q, cly0_d, clx1_q, clx1_d, cly1_q, cly1_d;

    // Sorted geometry and effective clip, computed in SETUP.
    logic signed [CORDW-1:0] xl_q, xl_d, xr_q, xr_d, yt_q, yt_d, yb_q, yb_d;
    logic signed [CORDW-1:0] cx0_q, cx0_d, cx1_q, cx1_d;
    logic signed [CORDW-1:0] lo_q, lo_d, hi_q, hi_d, ye_q, ye_d;
    logic signed [CORDW-1:0] y_q, y_d;

    logic signed [CORDW-1:0] xl_s, xr_s, yt_s, yb_s;
    logic signed [CORDW-1:0] ecx0_s, ecx1_s, ecy0_s, ecy1_s;
    logic signed [CORDW-1:0] ys_s, ye_s, lo_s, hi_s;
    logic                    empty_s;
    logic                    full_row_s, xl_vis_s, xr_vis_s, row_last_s;

    logic                    span_start_s, span_two_s;
    logic signed [CORDW-1:0] span_x0_s, span_x1_s, span_x_s;
    logic                    span_drawing_s, span_done_s;

    // A disabled clip becomes the full signed range, so one datapath serves both cases.
    assign xl_s    = smin(x0_q, x1_q);
    assign xr_s    = smax(x0_q, x1_q);
    assign yt_s    = smin(y0_q, y1_q);
    assign yb_s    = smax(y0_q, y1_q);
    assign ecx0_s  = clip_en_q ? clx0_q : C_MIN;
    assign ecx1_s  = clip_en_q ? clx1_q : C_MAX;
    assign ecy0_s  = clip_en_q ? cly0_q : C_MIN;
    assign ecy1_s  = clip_en_q ? cly1_q : C_MAX;
    assign ys_s    = smax(yt_s, ecy0_s);
    assign ye_s    = smin(yb_s, ecy1_s);
    assign lo_s    = smax(xl_s, ecx0_s);
    assign hi_s    = smin(xr_s, ecx1_s);
    assign empty_s = (ys_s > ye_s) || (lo_s > hi_s);

    assign full_row_s = (mode_q == DRAW_MODE_FILL) || (y_q == yt_q) || (y_q == yb_q);
    assign xl_vis_s   = (xl_q >= cx0_q) && (xl_q <= cx1_q);
    assign xr_vis_s   = (xr_q != xl_q) && (xr_q >= cx0_q) && (xr_q <= cx1_q);
    assign row_last_s = (y_q == ye_q);

    // Row/clip FSM: next state, latches and the per-row pixel list.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        clip_en_d    = clip_en_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        clx0_d       = clx0_q;
        cly0_d       = cly0_q;
        clx1_d       = clx1_q;
        cly1_d       = cly1_q;
        xl_d         = xl_q;
        xr_d         = xr_q;
        yt_d         = yt_q;
        yb_d         = yb_q;
        cx0_d        = cx0_q;
        cx1_d        = cx1_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        ye_d         = ye_q;
        y_d          = y_q;
        span_start_s = 1'b0;
        span_two_s   = 1'b0;
        span_x0_s    = lo_q;
        span_x1_s    = hi_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d    = mode_i;
                    clip_en_d = clip_en_i;
                    x0_d      = x0_i;
                    y0_d      = y0_i;
                    x1_d      = x1_i;
                    y1_d      = y1_i;
                    clx0_d    = clip_x0_i;
                    cly0_d    = clip_y0_i;
                    clx1_d    = clip_x1_i;
                    cly1_d    = clip_y1_i;
                    state_d   = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                xl_d  = xl_s;
                xr_d  = xr_s;
                yt_d  = yt_s;
                yb_d  = yb_s;
                cx0_d = ecx0_s;
                cx1_d = ecx1_s;
                lo_d  = lo_s;
                hi_d  = hi_s;
                ye_d  = ye_s;
                y_d   = ys_s;
                state_d = empty_s ? S_DONE : S_ROW;
            end
            S_ROW: begin
                if (full_row_s) begin
                    span_start_s = 1'b1;
                end else if (xl_vis_s && xr_vis_s) begin
                    span_start_s = 1'b1;
                    span_two_s   = 1'b1;
                    span_x0_s    = xl_q;
                    span_x1_s    = xr_q;
                end else if (xl_vis_s) begin
                    span_start_s = 1'b1;
                    span_x0_s    = xl_q;
                    span_x1_s    = xl_q;
                end else if (xr_vis_s) begin
                    span_start_s = 1'b1;
                    span_x0_s    = xr_q;
                    span_x1_s    = xr_q;
                end else begin
                    span_start_s = 1'b0;
                end
                // An empty outline row falls straight through to the next row.
                if (span_start_s) begin
                    state_d = S_DRAW;
                end else if (row_last_s) begin
                    state_d = S_DONE;
                end else begin
                    y_d     = y_q + ONE;
                    state_d = S_ROW;
                end
            end
            S_DRAW: begin
                if (!span_done_s) begin
                    state_d = S_DRAW;
                end else if (row_last_s) begin
                    state_d = S_DONE;
                end else begin
                    y_d     = y_q + ONE;
                    state_d = S_ROW;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_SETUP) || (state_d == S_ROW) || (state_d == S_DRAW);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            clip_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            clx0_q    <= '0;
            cly0_q    <= '0;
            clx1_q    <= '0;
            cly1_q    <= '0;
            xl_q      <= '0;
            xr_q      <= '0;
            yt_q      <= '0;
            yb_q      <= '0;
            cx0_q     <= '0;
            cx1_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            ye_q      <= '0;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            clip_en_q <= clip_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            clx0_q    <= clx0_d;
            cly0_q    <= cly0_d;
            clx1_q    <= clx1_d;
            cly1_q    <= cly1_d;
            xl_q      <= xl_d;
            xr_q      <= xr_d;
            yt_q      <= yt_d;
            yb_q      <= yb_d;
            cx0_q     <= cx0_d;
            cx1_q     <= cx1_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            ye_q      <= ye_d;
            y_q       <= y_d;
        end
    end

    draw_span_1d #(
        .CORDW(CORDW)
    ) u_span (
        .clk        (clk),
        .reset_i    (reset_i),
        .start_i    (span_start_s),
        .oe_i       (oe_i),
        .x_start_i  (span_x0_s),
        .x_end_i    (span_x1_s),
        .two_point_i(span_two_s),
        .x_o        (span_x_s),
        .drawing_o  (span_drawing_s),
        .done_o     (span_done_s)
    );

    assign x_o       = span_x_s;
    assign y_o       = y_q;
    assign drawing_o = span_drawing_s;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
